keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad and emits debounced key events for the seven-segment keypad lab. It sits directly downstream of the 60 Hz-class step-down divider: it consumes that divider's slow square wave (`scan_clk`) as a scan strobe while running entirely on the 12 MHz system clock. It drives one keypad column at a time, decodes the row returned, and rejects ghosting. It debounces both press and release, and hands a 4-bit key code plus a one-cycle valid pulse to the display logic.

## Interface
- `DEBOUNCE_SCANS`, default 2: consecutive identical full scans required to accept a press, and consecutive non-matching scans to accept a release; legal range 1..15.
- `clk_in`  input  1  system clock (12 MHz); the only clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `scan_clk`  input  1  slow square wave from the step-down divider; asynchronous to `clk_in`; each high and low phase lasts ≥3 `clk_in` cycles.
- `row_in`  input  4  keypad rows, active-low with external pull-ups, asynchronous.
- `col_out`  output  4  keypad column drive, active-low, exactly one bit low.
- `key_code`  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- `key_valid`  output  1  one-cycle pulse when a new press is accepted.
- `key_held`  output  1  high while the accepted key is considered pressed.

## Operation
- **Synchronisers:** `scan_clk` and `row_in` each pass through 2-flop synchronisers (reset to 0 / 4'hF respectively).
- **Scan tick:** `tick` = sync_scan & ~prev_scan, where `prev_scan` resets to 0. A tick is one `clk_in` cycle per `scan_clk` rising edge.
- **On each tick:**
  - Sample synchronised `row_in` for the current `col_idx`.
  - Advance `col_idx` 0→1→2→3→0, wrapping after 3.
  - `col_out` = ~(1 << col_idx), registered.
  - Rows therefore settle for one full `scan_clk` period before sampling.
- **Scan accumulation:**
  - Across the 4 ticks sampling columns 0..3, count the low row bits and capture the first hit (lowest column, then lowest row).
  - The tick sampling column 3 closes the scan.
  - Result: NONE if the count is 0 or the count is ≥2 (ghost/multi-press); otherwise KEY(code).
  - Accumulators clear after closing.
- **Debounce FSM** (evaluated once per closed scan):
  - IDLE:
    - KEY(k) → CAND with cand=k, cnt=1.
    - If DEBOUNCE_SCANS==1, go directly to PRESSED: accept k.
  - CAND:
    - KEY(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS, go to PRESSED and accept.
    - KEY(other) → cand=other, cnt=1.
    - NONE → IDLE.
  - PRESSED:
    - KEY(key_code) → rcnt=0, stay.
    - Anything else → rcnt+1; when rcnt reaches DEBOUNCE_SCANS → IDLE.
    - No new press is accepted until IDLE is reached.
  - Accept: `key_code` ← cand, `key_valid` pulses, `key_held` set.
- **Outputs:**
  - `key_held` = (state==PRESSED).
  - `key_code` holds its value after release until the next accepted press.
- **Reset values:** col_idx=0, `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, state=IDLE, cnt=rcnt=0, accumulators clear.
- **Reset timing:**
  - Reset is immediate (asynchronous), including mid-scan.
  - If `scan_clk` is high at reset release, one tick may fire within 3 cycles; it samples column 0 normally.

## Timing
- Pin-to-tick latency: `tick` asserts in the 3rd `clk_in` cycle after `scan_clk` rises (2 sync flops + edge).
- `col_out` changes on the clock edge ending the tick cycle.
- `key_valid` and `key_held` assert on the clock edge ending the tick that closes the accepting scan.
  - Press-to-event latency: DEBOUNCE_SCANS full scans (4·DEBOUNCE_SCANS ticks), plus partial-scan alignment.
- `key_valid` is high for exactly one `clk_in` cycle per accepted press, never on release.
- `key_held` falls on the edge ending the tick that closes the DEBOUNCE_SCANS-th non-matching scan.
- Throughput: at most one accepted press per DEBOUNCE_SCANS+1 scans.

## Test plan
- **Reset/idle:** assert `rst` mid-scan with key 6 pressed → `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0 immediately; no event for 10 scans with `row_in`=4'hF.
- **Single press:** `scan_clk` period 20 cycles, hold row 1 low whenever column 2 is driven, DEBOUNCE_SCANS=2 → exactly one `key_valid` pulse with `key_code`=4'b0110; `key_held`=1 from that edge.
- **Bounce:** key 6 present for 1 scan, absent for 1, present for 3 → one `key_valid`, only after the 2nd consecutive matching scan.
- **Release/hold:** after acceptance, hold key for 5 scans, then release → no extra pulses; `key_held` falls after 2 empty scans; `key_code` stays 6.
- **Ghosting:** keys 0 and 5 pressed together for 4 scans → no `key_valid`, state stays IDLE.
- **Key change:** key 3 accepted, then switched directly to key 12 → `key_held` drops after 2 scans, then key 12 accepted after 2 more scans with `key_code`=4'b1100.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: one column per scan_clk tick, ghost rejection, press/release debounce.
// Latency: key_valid fires on the tick closing the DEBOUNCE_SCANS-th matching scan; no backpressure (event pulse).
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       scan_clk,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic       scan_s1, scan_s2, prev_scan;
  logic [3:0] row_s1, row_s2;
  logic       tick;

  logic [1:0] col_idx;
  logic [1:0] acc_hits;
  logic [3:0] acc_code;

  logic [2:0] col_hits;
  logic [1:0] first_row;
  logic [2:0] sum_hits;
  logic [3:0] merged_code;
  logic       scan_done;
  logic       scan_key;

  state_t     state, state_n;
  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] rcnt, rcnt_n;
  logic       accept;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      scan_s1   <= 1'b0;
      scan_s2   <= 1'b0;
      prev_scan <= 1'b0;
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
    end else begin
      scan_s1   <= scan_clk;
      scan_s2   <= scan_s1;
      prev_scan <= scan_s2;
      row_s1    <= row_in;
      row_s2    <= row_s1;
    end
  end

  assign tick = scan_s2 & ~prev_scan;

  // Lowest row wins: iterate downward so the last hit written is the lowest index.
  always_comb begin
    col_hits  = 3'd0;
    first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        col_hits  = col_hits + 3'd1;
        first_row = 2'(r);
      end
    end
  end

  always_comb begin
    sum_hits    = {1'b0, acc_hits} + col_hits;
    merged_code = (acc_hits == 2'd0) ? {first_row, col_idx} : acc_code;
    scan_done   = tick && (col_idx == 2'd3);
    scan_key    = (sum_hits == 3'd1);
  end

  // acc_hits saturates at 2: anything beyond one hit is already a rejected scan.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      col_idx  <= 2'd0;
      col_out  <= 4'b1110;
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else if (tick) begin
      col_idx <= col_idx + 2'd1;
      col_out <= ~(4'b0001 << (col_idx + 2'd1));
      if (col_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_hits <= (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
        acc_code <= merged_code;
      end
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    accept  = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_key) begin
            cand_n = merged_code;
            cnt_n  = 4'd1;
            if (DS == 4'd1) begin
              state_n = PRESSED;
              accept  = 1'b1;
              rcnt_n  = 4'd0;
            end else begin
              state_n = CAND;
            end
          end
        end
        CAND: begin
          if (!scan_key) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else if (merged_code == cand) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DS) begin
              state_n = PRESSED;
              accept  = 1'b1;
              rcnt_n  = 4'd0;
            end
          end else begin
            cand_n = merged_code;
            cnt_n  = 4'd1;
          end
        end
        PRESSED: begin
          if (scan_key && (merged_code == key_code)) begin
            rcnt_n = 4'd0;
          end else begin
            rcnt_n = rcnt + 4'd1;
            if (rcnt + 4'd1 == DS) begin
              state_n = IDLE;
              rcnt_n  = 4'd0;
              cnt_n   = 4'd0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      rcnt      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      key_valid <= accept;
      if (accept) key_code <= cand_n;
    end
  end

  assign key_held = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural 4x4 keypad, scan-aligned phase table, scoreboard of expected key events.
module tb_keypad_scanner;

  logic       clk_in;
  logic       rst;
  logic       scan_clk;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int          checks;
  int          errors;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          scans;
    bit          push;
    logic [3:0]  push_code;
    bit          exp_held;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[23];

  keypad_scanner #(.DEBOUNCE_SCANS(2)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .scan_clk  (scan_clk),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // 20-cycle scan_clk period, phase-offset from clk_in.
  initial begin
    scan_clk = 1'b0;
    #3;
    forever #100 scan_clk = ~scan_clk;
  end

  // Key k sits at row k/4, column k%4; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk_in) begin
    if (!rst && key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: key_valid=1 key_code=%0d, required no pulse", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL valid_code: key_code=%0d, required %0d", key_code, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (4 * n) @(posedge scan_clk);
    repeat (5) @(posedge clk_in);
  endtask

  task automatic release_reset();
    @(negedge scan_clk);
    #20;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd0};
    vecs[1]  = '{16'h0040, 2, 1'b1, 4'd6,  1'b1, 4'd6};
    vecs[2]  = '{16'h0040, 5, 1'b0, 4'd0,  1'b1, 4'd6};
    vecs[3]  = '{16'h0000, 1, 1'b0, 4'd0,  1'b1, 4'd6};
    vecs[4]  = '{16'h0000, 1, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[5]  = '{16'h0040, 1, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[6]  = '{16'h0000, 1, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[7]  = '{16'h0040, 1, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[8]  = '{16'h0040, 1, 1'b1, 4'd6,  1'b1, 4'd6};
    vecs[9]  = '{16'h0040, 1, 1'b0, 4'd0,  1'b1, 4'd6};
    vecs[10] = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[11] = '{16'h0021, 4, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[12] = '{16'h0000, 1, 1'b0, 4'd0,  1'b0, 4'd6};
    vecs[13] = '{16'h0008, 2, 1'b1, 4'd3,  1'b1, 4'd3};
    vecs[14] = '{16'h1000, 1, 1'b0, 4'd0,  1'b1, 4'd3};
    vecs[15] = '{16'h1000, 1, 1'b0, 4'd0,  1'b0, 4'd3};
    vecs[16] = '{16'h1000, 1, 1'b0, 4'd0,  1'b0, 4'd3};
    vecs[17] = '{16'h1000, 1, 1'b1, 4'd12, 1'b1, 4'd12};
    vecs[18] = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd12};
    vecs[19] = '{16'h0022, 3, 1'b0, 4'd0,  1'b0, 4'd12};
    vecs[20] = '{16'h8000, 2, 1'b1, 4'd15, 1'b1, 4'd15};
    vecs[21] = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd15};
    vecs[22] = '{16'h0040, 2, 1'b1, 4'd6,  1'b1, 4'd6};

    checks = 0;
    errors = 0;
    keys   = 16'h0000;
    rst    = 1'b1;
    #1;
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_code", key_code, 4'd0);
    check("rst_key_valid", {3'b0, key_valid}, 4'd0);
    check("rst_key_held", {3'b0, key_held}, 4'd0);
    release_reset();

    // Each phase starts just after the tick that closes a scan.
    for (int i = 0; i < 23; i++) begin
      keys = vecs[i].keys;
      if (vecs[i].push) exp_q.push_back(vecs[i].push_code);
      wait_scans(vecs[i].scans);
      @(negedge clk_in);
      check($sformatf("v%0d_held", i), {3'b0, key_held}, {3'b0, vecs[i].exp_held});
      check($sformatf("v%0d_code", i), key_code, vecs[i].exp_code);
      check($sformatf("v%0d_col_out", i), col_out, 4'b1110);
    end

    // Asynchronous reset partway through a scan while key 6 is held.
    repeat (2) @(posedge scan_clk);
    repeat (5) @(posedge clk_in);
    #2;
    rst  = 1'b1;
    keys = 16'h0000;
    #1;
    check("midscan_col_out", col_out, 4'b1110);
    check("midscan_key_code", key_code, 4'd0);
    check("midscan_key_valid", {3'b0, key_valid}, 4'd0);
    check("midscan_key_held", {3'b0, key_held}, 4'd0);
    release_reset();
    wait_scans(10);
    @(negedge clk_in);
    check("idle_key_held", {3'b0, key_held}, 4'd0);
    check("idle_key_code", key_code, 4'd0);
    check("idle_col_out", col_out, 4'b1110);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_valid: %0d expected pulses not seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
